load_store_unit: RTL

- Initiator side of the data-memory port: accepts CPU load/store requests on byte addresses, drives the word-addressed memory (10-bit word address, synchronous write, combinational read data), and returns load data or store completion.
- Handles byte, halfword and word accesses, sign/zero extension, and read-modify-write for sub-word stores.
- Flags misaligned, out-of-range and illegal-size requests.
- Sits between the CPU execute/memory stage and the 1024x32 data memory.

---
 rtl/load_store_unit.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Initiator side of the data-memory port. It accepts CPU load and store
// requests on byte addresses and drives a word-addressed memory that has a
// synchronous write and a combinational read. It returns either the load
// data or a store completion.
//
// The unit handles byte, halfword and word accesses. Loads are sign- or
// zero-extended. Sub-word stores use read-modify-write. The unit flags
// misaligned, out-of-range and illegal-size requests.
//
// Optional build macro:
//   LSU_STATS_EN  When defined, builds saturating load/store/error counters.
//                 When undefined, the stat_* ports are tied to 0.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid / req_ready      request handshake; ready is high only in IDLE
//   req_write, req_size,       request attributes, latched at accept
//   req_signed, req_addr,
//   req_wdata
//   resp_valid                 one-cycle completion pulse
//   resp_rdata                 extended load data; 0 for stores and errors
//   resp_err                   error flag, valid with resp_valid
//   mem_addr, mem_we,          memory port (word address, write enable,
//   mem_wdata, mem_rdata       write data, combinational read data)
//   stat_loads, stat_stores,   statistics counters
//   stat_errs
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int unsigned MEM_AW = 10,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [CNT_W-1:0]  stat_loads,
    output logic [CNT_W-1:0]  stat_stores,
    output logic [CNT_W-1:0]  stat_errs
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_RD,
        S_STORE,
        S_RESP
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_e            state_q, state_d;
    logic [1:0]        lane_q, lane_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic              err_q, err_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;

    logic              accept;
    logic              acc_err;

    // Select the addressed lane from a memory word and extend it to 32 bits.
    function automatic logic [31:0] load_extract(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic [1:0]  size,
        input logic        sgn
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*lane +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: return {{24{sgn & b[7]}}, b};
            SZ_HALF: return {{16{sgn & h[15]}}, h};
            default: return word;
        endcase
    endfunction

    // Overlay the low bits of the store data onto the addressed lane(s).
    function automatic logic [31:0] store_merge(
        input logic [31:0] word,
        input logic [31:0] wd,
        input logic [1:0]  lane,
        input logic [1:0]  size
    );
        logic [31:0] w;
        w = word;
        case (size)
            SZ_BYTE: w[8*lane +: 8] = wd[7:0];
            SZ_HALF: begin
                if (lane[1]) w[31:16] = wd[15:0];
                else         w[15:0]  = wd[15:0];
            end
            default: w = wd;
        endcase
        return w;
    endfunction

    assign accept  = req_valid && (state_q == S_IDLE);

    assign acc_err = (req_size == 2'b11)
                   || ((req_size == SZ_HALF) && req_addr[0])
                   || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                   || (req_addr[31:MEM_AW+2] != '0);

    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        size_d       = size_q;
        signed_d     = signed_q;
        err_d        = err_q;
        wdata_d      = wdata_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_rdata_d = resp_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    lane_d       = req_addr[1:0];
                    size_d       = req_size;
                    signed_d     = req_signed;
                    wdata_d      = req_wdata;
                    err_d        = acc_err;
                    resp_rdata_d = '0;
                    if (acc_err) begin
                        // Error requests leave the memory port untouched.
                        state_d = S_RESP;
                    end else begin
                        mem_addr_d = req_addr[MEM_AW+1:2];
                        if (!req_write) begin
                            state_d = S_LOAD;
                        end else if (req_size == SZ_WORD) begin
                            mem_wdata_d = req_wdata;
                            state_d     = S_STORE;
                        end else begin
                            state_d = S_RMW_RD;
                        end
                    end
                end
            end
            S_LOAD: begin
                resp_rdata_d = load_extract(mem_rdata, lane_q, size_q, signed_q);
                state_d      = S_RESP;
            end
            S_RMW_RD: begin
                mem_wdata_d = store_merge(mem_rdata, wdata_q, lane_q, size_q);
                state_d     = S_STORE;
            end
            S_STORE: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            lane_q       <= '0;
            size_q       <= '0;
            signed_q     <= 1'b0;
            err_q        <= 1'b0;
            wdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            err_q        <= err_d;
            wdata_q      <= wdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // mem_we decodes the state register directly, so reset removes it at once.
    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_err   = (state_q == S_RESP) && err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_we     = (state_q == S_STORE);
    assign mem_wdata  = mem_wdata_q;

`ifdef LSU_STATS_EN
    logic             write_q, write_d;
    logic [CNT_W-1:0] stat_loads_q, stat_loads_d;
    logic [CNT_W-1:0] stat_stores_q, stat_stores_d;
    logic [CNT_W-1:0] stat_errs_q, stat_errs_d;

    always_comb begin
        write_d       = write_q;
        stat_loads_d  = stat_loads_q;
        stat_stores_d = stat_stores_q;
        stat_errs_d   = stat_errs_q;
        if (accept) begin
            write_d = req_write;
        end
        if (state_q == S_RESP) begin
            if (err_q) begin
                if (stat_errs_q != '1) stat_errs_d = stat_errs_q + CNT_W'(1);
            end else if (write_q) begin
                if (stat_stores_q != '1) stat_stores_d = stat_stores_q + CNT_W'(1);
            end else begin
                if (stat_loads_q != '1) stat_loads_d = stat_loads_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q       <= 1'b0;
            stat_loads_q  <= '0;
            stat_stores_q <= '0;
            stat_errs_q   <= '0;
        end else begin
            write_q       <= write_d;
            stat_loads_q  <= stat_loads_d;
            stat_stores_q <= stat_stores_d;
            stat_errs_q   <= stat_errs_d;
        end
    end

    assign stat_loads  = stat_loads_q;
    assign stat_stores = stat_stores_q;
    assign stat_errs   = stat_errs_q;
`else
    assign stat_loads  = '0;
    assign stat_stores = '0;
    assign stat_errs   = '0;
`endif

endmodule
